// File: rtl/lcd_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd_pattern_pkg
// Description : Shared definitions for the TFT test-pattern generator:
//               pattern mode encodings and the tile-count helper used to size
//               the cursor grid from the active resolution.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pattern_pkg;

    localparam logic [1:0] MODE_CHECKER  = 2'd0;
    localparam logic [1:0] MODE_BARS     = 2'd1;
    localparam logic [1:0] MODE_GRADIENT = 2'd2;
    localparam logic [1:0] MODE_BORDER   = 2'd3;

    // Number of tiles covering 'active' pixels when tiles are 2**shift wide;
    // a partial tile at the right/bottom edge still counts as a tile.
    function automatic int tile_count(input int active, input int shift);
        return (active + (1 << shift) - 1) >> shift;
    endfunction

endpackage : lcd_pattern_pkg
`default_nettype wire

// File: rtl/lcd_cursor_stepper.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cursor_stepper
// Description : Frame-rate divider and raster-order tile cursor. On every
//               frame tick with the cursor enabled, the divider counter is
//               compared to in_step_div; on equality it clears and the cursor
//               moves one tile right, wrapping to the next row and finally
//               back to tile (0,0).
// Ports       : in_clk, in_rst        - pixel clock, sync active-high reset
//               in_frame_tick         - one-cycle frame start enable
//               in_cursor_en          - gates counting and movement
//               in_step_div           - frames per step minus one
//               out_tilex/out_tiley   - registered cursor tile position
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cursor_stepper #(
    parameter int TILES_X = 60,
    parameter int TILES_Y = 34,
    parameter int TILE_W  = 7,
    parameter int STEP_W  = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_frame_tick,
    input  logic              in_cursor_en,
    input  logic [STEP_W-1:0] in_step_div,
    output logic [TILE_W-1:0] out_tilex,
    output logic [TILE_W-1:0] out_tiley
);

    localparam logic [TILE_W-1:0] c_last_x = TILE_W'(TILES_X - 1);
    localparam logic [TILE_W-1:0] c_last_y = TILE_W'(TILES_Y - 1);

    logic [STEP_W-1:0] r_count;
    logic [TILE_W-1:0] r_tilex;
    logic [TILE_W-1:0] r_tiley;

    // Equality (not >=) is deliberate: if the divider is lowered below the
    // current count, the counter runs on through its natural wrap before the
    // next step.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_count <= '0;
            r_tilex <= '0;
            r_tiley <= '0;
        end else if (in_cursor_en && in_frame_tick) begin
            if (r_count == in_step_div) begin
                r_count <= '0;
                if (r_tilex == c_last_x) begin
                    r_tilex <= '0;
                    r_tiley <= (r_tiley == c_last_y) ? '0 : r_tiley + TILE_W'(1);
                end else begin
                    r_tilex <= r_tilex + TILE_W'(1);
                end
            end else begin
                r_count <= r_count + STEP_W'(1);
            end
        end
    end

    assign out_tilex = r_tilex;
    assign out_tiley = r_tiley;

endmodule : lcd_cursor_stepper
`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pattern_gen
// Description : Selectable test-pattern generator (checker, colour bars,
//               gradient, border) with a moving red cursor tile, placed
//               between a TFT timing generator and the panel RGB pins.
//               One cycle of latency from every input to every output.
// Ports       : in_clk, in_rst           - pixel clock, sync active-high reset
//               in_frame_tick            - frame start enable (mode latch,
//                                          cursor step)
//               in_de, in_pixelx/y       - active pixel valid and position
//               in_mode                  - requested pattern
//               in_step_div              - frames per cursor step minus one
//               in_cursor_en             - cursor overlay and movement enable
//               out_de, out_r/g/b        - registered data enable and colour
//               out_tilex/out_tiley      - cursor tile position
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_pattern_gen
    import lcd_pattern_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int COORD_W    = 10,
    parameter int TILE_SHIFT = 3,
    parameter int R_W        = 5,
    parameter int G_W        = 6,
    parameter int B_W        = 5,
    parameter int STEP_W     = 8
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_frame_tick,
    input  logic                          in_de,
    input  logic [COORD_W-1:0]            in_pixelx,
    input  logic [COORD_W-1:0]            in_pixely,
    input  logic [1:0]                    in_mode,
    input  logic [STEP_W-1:0]             in_step_div,
    input  logic                          in_cursor_en,
    output logic                          out_de,
    output logic [R_W-1:0]                out_r,
    output logic [G_W-1:0]                out_g,
    output logic [B_W-1:0]                out_b,
    output logic [COORD_W-TILE_SHIFT-1:0] out_tilex,
    output logic [COORD_W-TILE_SHIFT-1:0] out_tiley
);

    localparam int TILE_W  = COORD_W - TILE_SHIFT;
    localparam int TILES_X = tile_count(H_ACTIVE, TILE_SHIFT);
    localparam int TILES_Y = tile_count(V_ACTIVE, TILE_SHIFT);

    localparam logic [COORD_W-1:0] c_x_last = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_y_last = COORD_W'(V_ACTIVE - 1);
    localparam logic [R_W-1:0]     c_r_half = {1'b0, {(R_W-1){1'b1}}};
    localparam logic [G_W-1:0]     c_g_half = {1'b0, {(G_W-1){1'b1}}};
    localparam logic [B_W-1:0]     c_b_half = {1'b0, {(B_W-1){1'b1}}};

    logic [1:0]        r_mode;
    logic              r_de;
    logic [R_W-1:0]    r_r;
    logic [G_W-1:0]    r_g;
    logic [B_W-1:0]    r_b;

    logic [1:0]        w_mode;
    logic [TILE_W-1:0] w_tx;
    logic [TILE_W-1:0] w_ty;
    logic [TILE_W-1:0] w_cur_x;
    logic [TILE_W-1:0] w_cur_y;
    logic [2:0]        w_chk;
    logic [2:0]        w_idx;
    logic              w_border;
    logic              w_cursor_hit;
    logic [R_W-1:0]    w_r;
    logic [G_W-1:0]    w_g;
    logic [B_W-1:0]    w_b;

    lcd_cursor_stepper #(
        .TILES_X (TILES_X),
        .TILES_Y (TILES_Y),
        .TILE_W  (TILE_W),
        .STEP_W  (STEP_W)
    ) u_stepper (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_frame_tick (in_frame_tick),
        .in_cursor_en  (in_cursor_en),
        .in_step_div   (in_step_div),
        .out_tilex     (w_cur_x),
        .out_tiley     (w_cur_y)
    );

    // The frame-tick pixel already belongs to the new frame, so it sees the
    // mode being latched on that same edge. The cursor, by contrast, is
    // still the pre-advance value.
    assign w_mode       = in_frame_tick ? in_mode : r_mode;
    assign w_tx         = in_pixelx[COORD_W-1:TILE_SHIFT];
    assign w_ty         = in_pixely[COORD_W-1:TILE_SHIFT];
    assign w_chk        = w_tx[2:0] ^ w_ty[2:0];
    assign w_idx        = in_pixelx[TILE_SHIFT+5:TILE_SHIFT+3];
    assign w_border     = (in_pixelx == '0) || (in_pixelx == c_x_last) ||
                          (in_pixely == '0) || (in_pixely == c_y_last);
    assign w_cursor_hit = in_cursor_en && (w_tx == w_cur_x) && (w_ty == w_cur_y);

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode)
            MODE_CHECKER: begin
                w_r = w_chk[0] ? c_r_half : '0;
                w_g = w_chk[1] ? c_g_half : '0;
                w_b = w_chk[2] ? c_b_half : '0;
            end
            MODE_BARS: begin
                w_r = {R_W{w_idx[2]}};
                w_g = {G_W{w_idx[1]}};
                w_b = {B_W{w_idx[0]}};
            end
            MODE_GRADIENT: begin
                // Top bits of the coordinate: a truncating scale to the
                // channel width.
                w_r = in_pixelx[COORD_W-1 -: R_W];
                w_g = in_pixely[COORD_W-1 -: G_W];
            end
            default: begin
                w_r = {R_W{w_border}};
                w_g = {G_W{w_border}};
                w_b = {B_W{w_border}};
            end
        endcase
        if (w_cursor_hit) begin
            w_r = '1;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_mode <= MODE_CHECKER;
            r_de   <= 1'b0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
        end else begin
            if (in_frame_tick) begin
                r_mode <= in_mode;
            end
            r_de <= in_de;
            r_r  <= in_de ? w_r : '0;
            r_g  <= in_de ? w_g : '0;
            r_b  <= in_de ? w_b : '0;
        end
    end

    assign out_de    = r_de;
    assign out_r     = r_r;
    assign out_g     = r_g;
    assign out_b     = r_b;
    assign out_tilex = w_cur_x;
    assign out_tiley = w_cur_y;

endmodule : lcd_pattern_gen
`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_pattern_gen
// Description : Self-checking bench for lcd_pattern_gen. A default 480x272
//               instance is driven with directed and random traffic against
//               an arithmetic reference model (cursor kept as a linear tile
//               index); an 800x480 / 16-pixel-tile instance checks grid
//               wrapping and gradient scaling for non-default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_pattern_gen;

    localparam int TX  = 60;
    localparam int TY  = 34;
    localparam int TX2 = 50;
    localparam int TY2 = 30;

    logic       clk;
    logic       rst;
    logic       tick, de, en;
    logic [9:0] px, py;
    logic [1:0] mode;
    logic [7:0] div;
    logic       o_de;
    logic [4:0] o_r, o_b;
    logic [5:0] o_g;
    logic [6:0] o_tx, o_ty;

    logic        tick2, de2, en2;
    logic [10:0] px2, py2;
    logic [1:0]  mode2;
    logic [7:0]  div2;
    logic        o2_de;
    logic [4:0]  o2_r, o2_b;
    logic [5:0]  o2_g;
    logic [6:0]  o2_tx, o2_ty;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mode, m_pos, m_cnt;
    int m2_mode, m2_pos;

    lcd_pattern_gen u_dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_frame_tick (tick),
        .in_de         (de),
        .in_pixelx     (px),
        .in_pixely     (py),
        .in_mode       (mode),
        .in_step_div   (div),
        .in_cursor_en  (en),
        .out_de        (o_de),
        .out_r         (o_r),
        .out_g         (o_g),
        .out_b         (o_b),
        .out_tilex     (o_tx),
        .out_tiley     (o_ty)
    );

    lcd_pattern_gen #(
        .H_ACTIVE   (800),
        .V_ACTIVE   (480),
        .COORD_W    (11),
        .TILE_SHIFT (4)
    ) u_dut2 (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_frame_tick (tick2),
        .in_de         (de2),
        .in_pixelx     (px2),
        .in_pixely     (py2),
        .in_mode       (mode2),
        .in_step_div   (div2),
        .in_cursor_en  (en2),
        .out_de        (o2_de),
        .out_r         (o2_r),
        .out_g         (o2_g),
        .out_b         (o2_b),
        .out_tilex     (o2_tx),
        .out_tiley     (o2_ty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected colour for the default instance, from the pattern rules.
    task automatic model_pixel(input int md, input int x, input int y,
                               input bit cen, input int pos,
                               output int er, output int eg, output int eb);
        int tx, ty, c, idx;
        bit brd;
        tx = x / 8;
        ty = y / 8;
        c  = tx ^ ty;
        er = 0; eg = 0; eb = 0;
        case (md)
            0: begin
                er = (c & 1) ? 15 : 0;
                eg = (c & 2) ? 31 : 0;
                eb = (c & 4) ? 15 : 0;
            end
            1: begin
                idx = (x / 64) % 8;
                er = (idx & 4) ? 31 : 0;
                eg = (idx & 2) ? 63 : 0;
                eb = (idx & 1) ? 31 : 0;
            end
            2: begin
                er = x / 32;
                eg = y / 16;
            end
            default: begin
                brd = (x == 0) || (x == 479) || (y == 0) || (y == 271);
                er = brd ? 31 : 0;
                eg = brd ? 63 : 0;
                eb = brd ? 31 : 0;
            end
        endcase
        if (cen && tx == pos % TX && ty == pos / TX) begin
            er = 31; eg = 0; eb = 0;
        end
    endtask

    task automatic cycle(input bit t, input bit d, input int x, input int y,
                         input int md, input int dv, input bit e);
        int er, eg, eb, emd;
        tick = t; de = d; px = 10'(x); py = 10'(y);
        mode = 2'(md); div = 8'(dv); en = e;
        emd = t ? md : m_mode;
        model_pixel(emd, x, y, e, m_pos, er, eg, eb);
        if (!d) begin
            er = 0; eg = 0; eb = 0;
        end
        if (t) m_mode = md;
        if (t && e) begin
            if (m_cnt == dv) begin
                m_cnt = 0;
                m_pos = (m_pos + 1) % (TX * TY);
            end else begin
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        check("de", int'(o_de), int'(d));
        check("r", int'(o_r), er);
        check("g", int'(o_g), eg);
        check("b", int'(o_b), eb);
        check("tilex", int'(o_tx), m_pos % TX);
        check("tiley", int'(o_ty), m_pos / TX);
    endtask

    // Second instance: gradient mode only, divider fixed at 0.
    task automatic cycle2(input bit t, input bit d, input int x, input int y, input bit e);
        int er, eg;
        tick2 = t; de2 = d; px2 = 11'(x); py2 = 11'(y);
        mode2 = 2'd2; div2 = 8'd0; en2 = e;
        er = x / 64;
        eg = y / 32;
        if (e && x / 16 == m2_pos % TX2 && y / 16 == m2_pos / TX2) begin
            er = 31; eg = 0;
        end
        if (!d) begin
            er = 0; eg = 0;
        end
        if (t && e) m2_pos = (m2_pos + 1) % (TX2 * TY2);
        @(posedge clk);
        #1;
        check("p2_de", int'(o2_de), int'(d));
        check("p2_r", int'(o2_r), er);
        check("p2_g", int'(o2_g), eg);
        check("p2_b", int'(o2_b), 0);
        check("p2_tilex", int'(o2_tx), m2_pos % TX2);
        check("p2_tiley", int'(o2_ty), m2_pos / TX2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b1; de = 1'b1; en = 1'b1; div = 8'd0; mode = 2'd3;
        tick2 = 1'b1; de2 = 1'b1; en2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            px = 10'($urandom_range(479));
            py = 10'($urandom_range(271));
            @(posedge clk);
            #1;
            check("rst_de", int'(o_de), 0);
            check("rst_rgb", int'({o_r, o_g, o_b}), 0);
            check("rst_tilex", int'(o_tx), 0);
            check("rst_tiley", int'(o_ty), 0);
            check("rst2_de", int'(o2_de), 0);
        end
        rst = 1'b0;
        tick2 = 1'b0; de2 = 1'b0; en2 = 1'b0;
        check("rst_release_de", int'(o_de), 0);
        m_mode = 0; m_pos = 0; m_cnt = 0;
        m2_mode = 0; m2_pos = 0;
    endtask

    // Random pixel, biased toward the current cursor tile so the overlay
    // is exercised.
    task automatic pick_xy(output int x, output int y);
        if ($urandom_range(3) == 0) begin
            x = (m_pos % TX) * 8 + int'($urandom_range(7));
            y = (m_pos / TX) * 8 + int'($urandom_range(7));
        end else begin
            x = int'($urandom_range(599));
            y = int'($urandom_range(299));
        end
    endtask

    initial begin
        int x, y, rdiv, rmode;
        bit ren;
        rst = 1'b1;
        tick = 0; de = 0; en = 0; px = 0; py = 0; mode = 0; div = 0;
        tick2 = 0; de2 = 0; en2 = 0; px2 = 0; py2 = 0; mode2 = 0; div2 = 0;

        do_reset();

        // Checker, cursor off
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 8, 0, 0, 0, 0);
        check("chk_8_0_r", int'(o_r), 15);
        check("chk_8_0_gb", int'({o_g, o_b}), 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("chk_0_0_rgb", int'({o_r, o_g, o_b}), 0);

        // Mid-frame mode request is ignored until the next frame tick
        cycle(0, 1, 64, 0, 1, 0, 0);
        check("latch_hold_b", int'(o_b), 0);
        cycle(1, 1, 64, 0, 1, 0, 0);
        cycle(0, 1, 64, 0, 1, 0, 0);
        check("latch_bars_b", int'(o_b), 31);
        check("latch_bars_rg", int'({o_r, o_g}), 0);

        // Cursor stepping every third frame
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 0, 2, 1);
        check("step9_tilex", int'(o_tx), 3);
        check("step9_tiley", int'(o_ty), 0);

        // Overlay priority over border mode
        do_reset();
        cycle(1, 1, 0, 0, 3, 0, 0);
        cycle(0, 1, 0, 0, 3, 0, 1);
        check("ovl_r", int'(o_r), 31);
        check("ovl_gb", int'({o_g, o_b}), 0);
        cycle(0, 1, 479, 100, 3, 0, 1);
        check("border_rgb", int'({o_r, o_g, o_b}), 16'hFFFF);
        cycle(0, 0, 479, 100, 3, 0, 1);
        check("de0_rgb", int'({o_r, o_g, o_b}), 0);
        check("de0_de", int'(o_de), 0);

        // Step every frame through a full grid wrap
        do_reset();
        for (int i = 0; i < 2100; i++) begin
            pick_xy(x, y);
            cycle(1, $urandom_range(3) != 0, x, y, $urandom_range(3), 0, 1);
        end

        // Random traffic: sparse ticks, divider and mode changes, enable toggles
        rdiv = 0; rmode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(63) == 0) rdiv = $urandom_range(7);
            if ($urandom_range(15) == 0) rmode = $urandom_range(3);
            ren = ($urandom_range(9) != 0);
            pick_xy(x, y);
            cycle($urandom_range(7) == 0, $urandom_range(3) != 0, x, y, rmode, rdiv, ren);
        end

        // Non-default geometry instance
        tick = 0; de = 0; en = 0;
        do_reset();
        cycle2(1, 0, 0, 0, 0);
        cycle2(0, 1, 799, 0, 0);
        check("p2_grad_799_r", int'(o2_r), 12);
        for (int i = 0; i < TX2 * TY2; i++) begin
            cycle2(1, $urandom_range(1), int'($urandom_range(799)), int'($urandom_range(479)), 1);
        end
        check("p2_wrap_tilex", int'(o2_tx), 0);
        check("p2_wrap_tiley", int'(o2_ty), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lcd_pattern_gen
`default_nettype wire
